// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and digit-count sizing helper.
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // ceil(bin_w * log10(2)) in fixed point
    function automatic int min_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction cell.
// Adds 3 to a digit of 5 or more so the following shift carries decimally.
module bcd_add3 (
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    assign o_q = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble converter, one shift per clock.
// Start/busy/done handshake, optional auto-convert, overflow saturation.
module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W     = 16,
    parameter int DIGITS    = 5,
    parameter int AUTO_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    state_t              r_state;
    logic [BIN_W-1:0]    r_bin;
    logic [DW-1:0]       r_dig;
    logic                r_ovf;
    logic [CW-1:0]       r_cnt;
    logic [BIN_W-1:0]    r_last;
    logic                r_busy;
    logic                r_done;
    logic [DW-1:0]       r_bcd;
    logic                r_ovf_o;

    logic [DW-1:0]       w_adj;
    logic [DW+BIN_W:0]   w_sh;
    logic [DW-1:0]       w_dig_nx;
    logic [BIN_W-1:0]    w_bin_nx;
    logic                w_ovf_nx;
    logic                w_trig;
    logic                w_last_cyc;
    logic [DW-1:0]       w_nines;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_d (r_dig[4*g +: 4]),
            .o_q (w_adj[4*g +: 4])
        );
    end

    // Bit DW+BIN_W is the bit pushed out of the top digit
    assign w_sh       = {w_adj, r_bin, 1'b0};
    assign w_bin_nx   = w_sh[BIN_W-1:0];
    assign w_dig_nx   = w_sh[DW+BIN_W-1:BIN_W];
    assign w_ovf_nx   = r_ovf | w_sh[DW+BIN_W];
    assign w_last_cyc = (r_cnt == CW'(BIN_W - 1));
    assign w_nines    = {DIGITS{BCD_NINE}};
    assign w_trig     = (AUTO_MODE != 0) ? (bin_in != r_last) : start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_dig   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_last  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_ovf_o <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_bin   <= bin_in;
                        r_dig   <= '0;
                        r_ovf   <= 1'b0;
                        r_last  <= bin_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bin <= w_bin_nx;
                    r_dig <= w_dig_nx;
                    r_ovf <= w_ovf_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_cyc) begin
                        r_bcd   <= w_ovf_nx ? w_nines : w_dig_nx;
                        r_ovf_o <= w_ovf_nx;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_ovf_o;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench for binary_to_bcd_seq across four parameter sets.
// Stimulus pushes expected results; per-DUT monitors pop on done.
module tb_binary_to_bcd_seq;

    typedef struct packed {
        logic [19:0] bcd;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exp_t q_a[$], q_b[$], q_c[$], q_d[$];
    exp_t ea, eb, ec, ed;
    int   n_done_c = 0;

    // A: 16-bit, 5 digits
    logic        start_a;
    logic [15:0] bin_a;
    logic        busy_a, done_a, ovf_a;
    logic [19:0] bcd_a;
    // B: 8-bit, 2 digits
    logic        start_b;
    logic [7:0]  bin_b;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    // C: 6-bit, 2 digits, auto
    logic        start_c;
    logic [5:0]  bin_c;
    logic        busy_c, done_c, ovf_c;
    logic [7:0]  bcd_c;
    // D: 10-bit, 4 digits
    logic        start_d;
    logic [9:0]  bin_d;
    logic        busy_d, done_d, ovf_d;
    logic [15:0] bcd_d;

    binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .AUTO_MODE(0)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
    );
    binary_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .AUTO_MODE(0)) u_b (
        .clk(clk), .rst(rst_n), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
    );
    binary_to_bcd_seq #(.BIN_W(6), .DIGITS(2), .AUTO_MODE(1)) u_c (
        .clk(clk), .rst(rst_n), .start(start_c), .bin_in(bin_c),
        .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c)
    );
    binary_to_bcd_seq #(.BIN_W(10), .DIGITS(4), .AUTO_MODE(0)) u_d (
        .clk(clk), .rst(rst_n), .start(start_d), .bin_in(bin_d),
        .busy(busy_d), .done(done_d), .bcd_out(bcd_d), .overflow(ovf_d)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got=unexpected expected=none at %0t", nm, $time);
    endtask

    function automatic exp_t ref_bcd(input int v, input int nd);
        exp_t r;
        int   lim;
        int   t;
        r   = '0;
        lim = 1;
        t   = v;
        for (int k = 0; k < nd; k++) lim *= 10;
        if (v >= lim) begin
            r.ovf = 1'b1;
            for (int k = 0; k < nd; k++) r.bcd[4*k +: 4] = 4'd9;
        end else begin
            for (int k = 0; k < nd; k++) begin
                r.bcd[4*k +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [19:0] b, input logic o);
        exp_t r;
        r.bcd = b;
        r.ovf = o;
        return r;
    endfunction

    always @(negedge clk) if (done_a) begin
        if (q_a.size() == 0) flag("a_extra_done");
        else begin
            ea = q_a.pop_front();
            chk("a_bcd", 32'(bcd_a), 32'(ea.bcd));
            chk("a_ovf", 32'(ovf_a), 32'(ea.ovf));
        end
    end
    always @(negedge clk) if (done_b) begin
        if (q_b.size() == 0) flag("b_extra_done");
        else begin
            eb = q_b.pop_front();
            chk("b_bcd", 32'(bcd_b), 32'(eb.bcd));
            chk("b_ovf", 32'(ovf_b), 32'(eb.ovf));
        end
    end
    always @(negedge clk) if (done_c) begin
        n_done_c++;
        if (q_c.size() == 0) flag("c_extra_done");
        else begin
            ec = q_c.pop_front();
            chk("c_bcd", 32'(bcd_c), 32'(ec.bcd));
            chk("c_ovf", 32'(ovf_c), 32'(ec.ovf));
        end
    end
    always @(negedge clk) if (done_d) begin
        if (q_d.size() == 0) flag("d_extra_done");
        else begin
            ed = q_d.pop_front();
            chk("d_bcd", 32'(bcd_d), 32'(ed.bcd));
            chk("d_ovf", 32'(ovf_d), 32'(ed.ovf));
        end
    end

    task automatic wait_done(input int which);
        logic d;
        for (int i = 0; i < 100; i++) begin
            case (which)
                0: d = done_a;
                1: d = done_b;
                2: d = done_c;
                default: d = done_d;
            endcase
            if (d) return;
            @(negedge clk);
        end
        chk($sformatf("timeout_done_%0d", which), 32'd0, 32'd1);
    endtask

    task automatic go_a(input logic [15:0] v, input exp_t e);
        bin_a   = v;
        start_a = 1'b1;
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic go_b(input logic [7:0] v, input exp_t e);
        bin_b   = v;
        start_b = 1'b1;
        q_b.push_back(e);
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1);
    endtask

    initial begin
        int cnt;
        int v;
        rst_a = 1'b0; rst_n = 1'b0;
        start_a = 0; start_b = 0; start_c = 0; start_d = 0;
        bin_a = '0; bin_b = '0; bin_c = '0; bin_d = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_bcd", 32'(bcd_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        rst_a = 1'b1; rst_n = 1'b1;
        @(negedge clk);

        // Full-scale value, latency and busy width
        go_a(16'hFFFF, mk(20'h65535, 1'b0));
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_a) break;
            if (busy_a) cnt++;
            @(negedge clk);
        end
        chk("a_done_seen", 32'(done_a), 32'd1);
        chk("a_busy_cycles", 32'(cnt), 32'd16);
        chk("a_busy_at_done", 32'(busy_a), 32'd0);

        // Zero, then back-to-back start in the done cycle
        go_a(16'd0, mk(20'h0, 1'b0));
        wait_done(0);
        go_a(16'd12345, mk(20'h12345, 1'b0));
        wait_done(0);

        // Start and bin_in changes while busy are ignored
        go_a(16'd4321, mk(20'h04321, 1'b0));
        repeat (3) @(negedge clk);
        bin_a = 16'd1111; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; bin_a = 16'd7777;
        wait_done(0);
        repeat (20) @(negedge clk);
        chk("a_hold_bcd", 32'(bcd_a), 32'h04321);

        // Reset in the fifth shift cycle aborts without done
        bin_a = 16'd54321; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        chk("abort_bcd", 32'(bcd_a), 32'd0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        repeat (20) @(negedge clk);
        go_a(16'd999, mk(20'h00999, 1'b0));
        wait_done(0);

        // Too few digits: saturate and flag, then recover
        go_b(8'd200, mk(20'h99, 1'b1));
        go_b(8'd42, mk(20'h42, 1'b0));
        go_b(8'd99, mk(20'h99, 1'b0));
        go_b(8'd100, mk(20'h99, 1'b1));
        go_b(8'd255, mk(20'h99, 1'b1));
        go_b(8'd0, mk(20'h00, 1'b0));

        // Auto mode: converts only on value change
        repeat (5) @(negedge clk);
        bin_c = 6'd59;
        q_c.push_back(mk(20'h59, 1'b0));
        @(negedge clk);
        wait_done(2);
        repeat (5) @(negedge clk);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        repeat (10) @(negedge clk);
        bin_c = 6'd7;
        q_c.push_back(mk(20'h07, 1'b0));
        @(negedge clk);
        wait_done(2);
        repeat (12) @(negedge clk);
        chk("c_done_count", 32'(n_done_c), 32'd2);

        // Every 10-bit value, permuted order, against the model
        for (int i = 0; i < 1024; i++) begin
            v = (i * 397) % 1024;
            bin_d   = 10'(v);
            start_d = 1'b1;
            q_d.push_back(ref_bcd(v, 4));
            @(negedge clk);
            start_d = 1'b0;
            wait_done(3);
        end
        repeat (5) @(negedge clk);

        chk("a_queue_empty", 32'(q_a.size()), 32'd0);
        chk("b_queue_empty", 32'(q_b.size()), 32'd0);
        chk("c_queue_empty", 32'(q_c.size()), 32'd0);
        chk("d_queue_empty", 32'(q_d.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
